mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Initiator side of the data-memory port: turns single core load/store requests (byte/half/word) into line-wide memory accesses.
- On the memory side it drives address, read/write select, enable, line-wide write data and a bit-granular byte-keep mask; it receives line-wide read data back.
- Sits between the core's load/store unit and the data memory. Models a fixed memory access latency and returns aligned, sign- or zero-extended load data.

Parameters:
- ADDR_SIZE, 32, byte address width.
- WD_SIZE, 128, memory line width in bits; must be a power of two and at least 32.
- REG_SIZE, 32, core data width.
- MEM_LATENCY, 4, cycles mem_op_en is held per access; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_SIZE  byte address
- req_wr  in  1  0 = load, 1 = store
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: zero-extend when 1
- req_wdata  in  REG_SIZE  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  REG_SIZE  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- mem_addr  out  ADDR_SIZE  line-aligned address
- mem_op_rd_wr  out  1  0 = read, 1 = write
- mem_op_en  out  1  memory operation enable
- mem_wr_data  out  WD_SIZE  line-positioned write data
- mem_wr_keep  out  WD_SIZE  all eight bits of a byte set to 1 = write that byte
- mem_rd_data  in  WD_SIZE  line read data

Behaviour:
- Reset: state goes to IDLE. All outputs are 0 except req_ready, which is 1.
- Reset mid-access: the access aborts, mem_op_en is 0 on the next cycle, and no response is issued.
- Offset: OFF = req_addr[log2(WD_SIZE/8)-1:0].
- Line address: mem_addr = req_addr with the OFF bits cleared.
- Error: resp_err = 1 when any of the following holds:
  - req_size == 11;
  - half access with OFF[0] != 0;
  - word access with OFF[1:0] != 0.
- Aligned accesses never cross a line.
- FSM IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch addr, wr, size, unsigned and wdata.
  - Error → RESP; otherwise → ACCESS, loading the counter with MEM_LATENCY-1.
- FSM ACCESS:
  - req_ready = 0, mem_op_en = 1, mem_op_rd_wr = latched wr.
  - Counter decrements each cycle. When the counter is 0, loads capture mem_rd_data → RESP.
- FSM RESP:
  - resp_valid = 1 for exactly one cycle; there is no backpressure.
  - Next state is IDLE.
- Latency: the accept edge is cycle 0. mem_op_en is high in cycles 1..MEM_LATENCY and resp_valid is high in cycle MEM_LATENCY+1. For errors, resp_valid is high in cycle 1 and mem_op_en never asserts.
- Throughput: the next request can be accepted in the cycle after resp_valid, i.e. the first IDLE cycle.
- Store data: mem_wr_data places the low 8/16/32 bits of wdata at bit OFF*8; all other bits are 0.
- Store keep: mem_wr_keep has 0xFF in each written byte lane and 0 elsewhere.
- Loads: mem_wr_data = 0 and mem_wr_keep = 0.
- Load result: take the 1/2/4 bytes of the captured line starting at OFF. Sign-extend from the top bit unless unsigned; word loads ignore req_unsigned.
- Outside ACCESS: mem_op_en = 0; mem_addr, mem_op_rd_wr, mem_wr_data and mem_wr_keep hold their last values.
- resp_rdata and resp_err: valid only while resp_valid = 1; 0 otherwise.
- req_valid during busy states: ignored and not latched; the requester holds it until req_ready.

Test Plan:
- Store byte, addr 0x105, wdata 0x123456AB, MEM_LATENCY = 4 → cycles 1-4:
  - mem_op_en = 1, mem_op_rd_wr = 1, mem_addr = 0x100;
  - mem_wr_keep[47:40] = 0xFF, rest 0; mem_wr_data[47:40] = 0xAB, rest 0;
  - cycle 5: resp_valid = 1, resp_rdata = 0, resp_err = 0.
- Load byte signed at 0x103, mem_rd_data[31:24] = 0x80 → resp_rdata = 0xFFFFFF80 at cycle 5. Same with req_unsigned = 1 → 0x00000080.
- Load word at 0x10C, mem_rd_data[127:96] = 0xDEADBEEF → mem_op_rd_wr = 0, mem_addr = 0x100, resp_rdata = 0xDEADBEEF at cycle 5.
- Load half at 0x101; separately, req_size = 11 → resp_valid and resp_err = 1 at cycle 1, resp_rdata = 0, mem_op_en never asserts.
- Back-to-back: req_valid held high with two stores → req_ready low in cycles 1-5. Second request accepted at cycle 6 with mem_op_en in cycles 7-10.
- Reset asserted in cycle 2 of a load → mem_op_en = 0 and req_ready = 1 the next cycle; no resp_valid is ever seen for that load.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Initiator side of the data-memory port. Accepts one core load/store
//   (byte/half/word) at a time, turns it into a line-wide memory access held
//   for MEM_LATENCY cycles, then returns a one-cycle response carrying the
//   aligned, sign- or zero-extended load data or an error flag.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE. While busy, req_valid is ignored, and the
//   requester keeps it asserted until it sees req_ready. resp_valid is a
//   single-cycle pulse with no backpressure.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        core request handshake
//   req_addr, req_wr           byte address, 0 = load / 1 = store
//   req_size, req_unsigned     00 byte, 01 half, 10 word, 11 illegal; zero-extend loads
//   req_wdata                  right-aligned store data
//   resp_valid/rdata/err       response pulse, load result, misaligned/illegal flag
//   mem_addr, mem_op_rd_wr     line-aligned address, 0 = read / 1 = write
//   mem_op_en                  high for the whole access
//   mem_wr_data, mem_wr_keep   line-positioned store data and bit-granular byte mask
//   mem_rd_data                line read data
//   state (internal, enum)     FSM state, visible to bound checkers
module mem_req_ctrl #(
  parameter int ADDR_SIZE   = 32,
  parameter int WD_SIZE     = 128,
  parameter int REG_SIZE    = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic                 req_wr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [REG_SIZE-1:0]  req_wdata,
  output logic                 resp_valid,
  output logic [REG_SIZE-1:0]  resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_op_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  output logic [WD_SIZE-1:0]   mem_wr_keep,
  input  logic [WD_SIZE-1:0]   mem_rd_data
);

  localparam int OFF_W = $clog2(WD_SIZE/8);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [OFF_W-1:0]   off_q;
  logic               wr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               err_q;
  logic [WD_SIZE-1:0] line_q;

  logic [OFF_W-1:0]    req_off;
  logic                req_err;
  logic [REG_SIZE-1:0] size_mask;
  logic [WD_SIZE-1:0]  lane_data;
  logic [WD_SIZE-1:0]  lane_keep;
  logic [31:0]         rd_lane;
  logic [REG_SIZE-1:0] load_val;

  assign req_off = req_addr[OFF_W-1:0];

  // Alignment check; aligned accesses can never straddle a line.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_off[0];
      2'b10:   req_err = |req_off[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Store data/keep: mask to the access width, then move to byte lane OFF.
  always_comb begin
    size_mask = '0;
    case (req_size)
      2'b00:   size_mask = REG_SIZE'(8'hFF);
      2'b01:   size_mask = REG_SIZE'(16'hFFFF);
      default: size_mask = REG_SIZE'(32'hFFFF_FFFF);
    endcase
  end

  assign lane_data = WD_SIZE'(req_wdata & size_mask) << {req_off, 3'b000};
  assign lane_keep = WD_SIZE'(size_mask) << {req_off, 3'b000};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_op_en  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_op_en = 1'b1;
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, memory-side registers and latency counter.
  // Memory-side outputs are only reloaded for accesses that go to memory,
  // so they keep their last values across errored requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      off_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      line_q       <= '0;
      mem_addr     <= '0;
      mem_op_rd_wr <= 1'b0;
      mem_wr_data  <= '0;
      mem_wr_keep  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q  <= req_off;
            wr_q   <= req_wr;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            err_q  <= req_err;
            if (!req_err) begin
              cnt          <= CNT_W'(MEM_LATENCY - 1);
              mem_addr     <= {req_addr[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
              mem_op_rd_wr <= req_wr;
              mem_wr_data  <= req_wr ? lane_data : '0;
              mem_wr_keep  <= req_wr ? lane_keep : '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0 && !wr_q) line_q <= mem_rd_data;
        end
        default: ;
      endcase
    end
  end

  // Load result: bytes starting at OFF, extended from the access's top bit.
  assign rd_lane = 32'(line_q >> {off_q, 3'b000});

  always_comb begin
    load_val = '0;
    case (size_q)
      2'b00:   load_val = uns_q ? REG_SIZE'(rd_lane[7:0])
                                : {{(REG_SIZE-8){rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   load_val = uns_q ? REG_SIZE'(rd_lane[15:0])
                                : {{(REG_SIZE-16){rd_lane[15]}}, rd_lane[15:0]};
      default: load_val = REG_SIZE'(rd_lane);
    endcase
  end

  assign resp_rdata = (resp_valid && !err_q && !wr_q) ? load_val : '0;
  assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: directed vector table, random transactions
// against a byte-level reference model, and hand-written multi-cycle
// sequences (back-to-back with held req_valid, reset mid-access).
module tb_mem_req_ctrl;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_wr;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [31:0]  mem_addr;
  logic         mem_op_rd_wr;
  logic         mem_op_en;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_wr_keep;
  logic [127:0] mem_rd_data;

  mem_req_ctrl #(
    .ADDR_SIZE(32), .WD_SIZE(128), .REG_SIZE(32), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_op_rd_wr(mem_op_rd_wr), .mem_op_en(mem_op_en),
    .mem_wr_data(mem_wr_data), .mem_wr_keep(mem_wr_keep),
    .mem_rd_data(mem_rd_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [1:0]   size;
    logic         uns;
    logic [31:0]  wdata;
    logic [127:0] line;
    logic         exp_err;
    logic [31:0]  exp_rdata;
    logic [31:0]  exp_maddr;
    logic [127:0] exp_wdata;
    logic [127:0] exp_keep;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0]  last_maddr;
  logic         last_rdwr;
  logic [127:0] last_wd;
  logic [127:0] last_keep;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic on the request.
  function automatic vec_t make_vec(input logic [31:0] addr, input logic wr,
                                    input logic [1:0] size, input logic uns,
                                    input logic [31:0] wdata, input logic [127:0] line);
    vec_t v;
    int off, nb;
    logic [31:0] val;
    v.addr = addr; v.wr = wr; v.size = size; v.uns = uns; v.wdata = wdata; v.line = line;
    off = int'(addr % 16);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    v.exp_err   = (size == 2'd3) || ((off % nb) != 0);
    v.exp_maddr = addr - 32'(off);
    v.exp_wdata = '0;
    v.exp_keep  = '0;
    v.exp_rdata = '0;
    if (!v.exp_err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) begin
          v.exp_wdata[(off+i)*8 +: 8] = wdata[i*8 +: 8];
          v.exp_keep[(off+i)*8 +: 8]  = 8'hFF;
        end
      end else begin
        val = '0;
        for (int i = 0; i < nb; i++) val[i*8 +: 8] = line[(off+i)*8 +: 8];
        if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        v.exp_rdata = val;
      end
    end
    return v;
  endfunction

  // Driver + cycle checker for one isolated transaction. Entered and left
  // just after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    int lat;
    req_addr = v.addr; req_wr = v.wr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata; mem_rd_data = v.line;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after the accept edge: the DUT must use latched values
    req_valid = 1'b0;
    req_addr = $urandom; req_wr = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    lat = v.exp_err ? 1 : L + 1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("mem_op_en", mem_op_en, (!v.exp_err && k <= L));
      chk("req_ready_busy", req_ready, 0);
      chk("resp_valid", resp_valid, (k == lat));
      if (!v.exp_err && k <= L) begin
        chk("mem_addr", mem_addr, v.exp_maddr);
        chk("mem_op_rd_wr", mem_op_rd_wr, v.wr);
        chk("mem_wr_data", mem_wr_data, v.exp_wdata);
        chk("mem_wr_keep", mem_wr_keep, v.exp_keep);
      end
      if (v.exp_err) begin
        chk("mem_addr_hold", mem_addr, last_maddr);
        chk("mem_rd_wr_hold", mem_op_rd_wr, last_rdwr);
        chk("mem_wr_data_hold", mem_wr_data, last_wd);
        chk("mem_wr_keep_hold", mem_wr_keep, last_keep);
      end
      chk("resp_rdata", resp_rdata, (k == lat) ? v.exp_rdata : 32'h0);
      chk("resp_err", resp_err, (k == lat) ? v.exp_err : 1'b0);
    end
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("resp_valid_idle", resp_valid, 0);
    chk("mem_op_en_idle", mem_op_en, 0);
    if (!v.exp_err) begin
      last_maddr = v.exp_maddr; last_rdwr = v.wr;
      last_wd = v.exp_wdata; last_keep = v.exp_keep;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v, v1, v2;
    logic [31:0] a;
    logic [1:0]  sz;

    // directed table: expected values written out by hand
    tbl[0] = '{32'h105, 1'b1, 2'd0, 1'b0, 32'h1234_56AB, 128'h0,
               1'b0, 32'h0, 32'h100,
               128'h0000_AB00_0000_0000, 128'h0000_FF00_0000_0000};
    tbl[1] = '{32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 128'h1111_2222_3333_4444_5555_6666_807F_7F7F,
               1'b0, 32'hFFFF_FF80, 32'h100, 128'h0, 128'h0};
    tbl[2] = '{32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 128'h1111_2222_3333_4444_5555_6666_807F_7F7F,
               1'b0, 32'h0000_0080, 32'h100, 128'h0, 128'h0};
    tbl[3] = '{32'h10C, 1'b0, 2'd2, 1'b1, 32'h0, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000,
               1'b0, 32'hDEAD_BEEF, 32'h100, 128'h0, 128'h0};
    tbl[4] = '{32'h101, 1'b0, 2'd1, 1'b0, 32'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               1'b1, 32'h0, 32'h100, 128'h0, 128'h0};
    tbl[5] = '{32'h100, 1'b0, 2'd3, 1'b0, 32'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               1'b1, 32'h0, 32'h100, 128'h0, 128'h0};
    tbl[6] = '{32'h10E, 1'b0, 2'd1, 1'b0, 32'h0, 128'h8001_0000_0000_0000_0000_0000_0000_0000,
               1'b0, 32'hFFFF_8001, 32'h100, 128'h0, 128'h0};
    tbl[7] = '{32'h4000_0108, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 128'h0,
               1'b0, 32'h0, 32'h4000_0100,
               128'h0000_0000_CAFE_F00D_0000_0000_0000_0000,
               128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000};
    tbl[8] = '{32'h102, 1'b1, 2'd1, 1'b0, 32'hFFFF_1234, 128'h0,
               1'b0, 32'h0, 32'h100, 128'h1234_0000, 128'hFFFF_0000};
    tbl[9] = '{32'h2106, 1'b0, 2'd1, 1'b1, 32'h0, 128'h9ABC_0000_0000_0000,
               1'b0, 32'h0000_9ABC, 32'h2100, 128'h0, 128'h0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; mem_rd_data = '0;
    last_maddr = '0; last_rdwr = 1'b0; last_wd = '0; last_keep = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_en", mem_op_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd_wr", mem_op_rd_wr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_mem_wr_keep", mem_wr_keep, 0);
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      v = make_vec(a, 1'($urandom), sz, 1'($urandom), $urandom,
                   {$urandom, $urandom, $urandom, $urandom});
      run_txn(v);
    end

    // back-to-back: req_valid held high across two stores
    v1 = make_vec(32'h0000_0204, 1'b1, 2'd2, 1'b0, 32'h1122_3344, 128'h0);
    v2 = make_vec(32'h0000_030B, 1'b1, 2'd0, 1'b0, 32'h0000_0055, 128'h0);
    req_addr = v1.addr; req_wr = 1'b1; req_size = v1.size; req_unsigned = 1'b0;
    req_wdata = v1.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = v2.addr; req_size = v2.size; req_wdata = v2.wdata;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("b2b_req_ready", req_ready, (c == 6));
      chk("b2b_mem_en", mem_op_en, ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
      chk("b2b_resp_valid", resp_valid, (c == 5 || c == 11));
      if (c >= 1 && c <= 4) begin
        chk("b2b_addr1", mem_addr, v1.exp_maddr);
        chk("b2b_data1", mem_wr_data, v1.exp_wdata);
      end
      if (c >= 7 && c <= 10) begin
        chk("b2b_addr2", mem_addr, v2.exp_maddr);
        chk("b2b_keep2", mem_wr_keep, v2.exp_keep);
        chk("b2b_data2", mem_wr_data, v2.exp_wdata);
      end
      if (c == 6) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    last_maddr = v2.exp_maddr; last_rdwr = 1'b1;
    last_wd = v2.exp_wdata; last_keep = v2.exp_keep;
    @(posedge clk); #1;

    // reset asserted in cycle 2 of a load: access aborts, no response
    req_addr = 32'h0000_0500; req_wr = 1'b0; req_size = 2'd2; req_valid = 1'b1;
    mem_rd_data = 128'h1234_5678;
    @(posedge clk); #1;               // cycle 1
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_en_c1", mem_op_en, 1);
    @(posedge clk); #1;               // cycle 2
    reset = 1'b1;
    @(posedge clk); #1;               // cycle 3
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", mem_op_en, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_addr", mem_addr, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", resp_valid, 0);
      chk("rst_mid_no_en", mem_op_en, 0);
    end
    last_maddr = '0; last_rdwr = 1'b0; last_wd = '0; last_keep = '0;
    @(posedge clk); #1;

    // controller still works after the abort; an error keeps reset values
    run_txn(tbl[5]);
    run_txn(tbl[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
